// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
package dmem_pkg;

  localparam int WORD_W = 32;
  localparam int BE_W   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Legal enables: one byte, an aligned halfword, or the full word.
  function automatic logic be_legal(input logic [BE_W-1:0] be);
    logic ok;
    case (be)
      4'b0001, 4'b0010,
      4'b0100, 4'b1000,
      4'b0011, 4'b1100,
      4'b1111: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word RAM with byte-write mask and registered read word.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 4096,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic              re,
  input  logic              rclr,
  input  logic [AW-1:0]     addr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [BE_W-1:0]   wmask,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int k = 0; k < BE_W; k++) begin
        if (wmask[k]) mem[addr][8*k +: 8] <= wdata[8*k +: 8];
      end
    end
  end

  // Read word only changes on a completing read; held otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     rdata <= '0;
    else if (re)   rdata <= rclr ? '0 : mem[addr];
  end

endmodule

// File: rtl/dmem_responder.sv
// Memory-side dmem responder: one access at a time, latency-timed valid pulse.
// Optional DMEM_RESP_ERR_EN adds dmem_error for out-of-range/misaligned access.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS   = 4096,
  parameter logic [31:0] BASE_ADDR     = 32'h0000_0000,
  parameter int          READ_LATENCY  = 1,
  parameter int          WRITE_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dmem_read_ready,
  input  logic [31:0] dmem_read_address,
  input  logic        dmem_write_ready,
  input  logic [31:0] dmem_write_address,
  input  logic [31:0] dmem_write_data,
  input  logic [3:0]  dmem_write_byte,
  output logic [31:0] dmem_read_data,
  output logic        dmem_read_valid,
`ifdef DMEM_RESP_ERR_EN
  output logic        dmem_error,
`endif
  output logic        dmem_write_valid
);

  localparam int AW = $clog2(DEPTH_WORDS);

  state_t            state, next;
  logic [3:0]        cnt;
  logic              op_wr;
  logic [31:0]       addr_q, data_q;
  logic [BE_W-1:0]   byte_q;

  logic              start, enter_done, err, acc_wr;
  logic [31:0]       acc_addr, acc_data;
  logic [BE_W-1:0]   acc_byte;
  logic [3:0]        lat;
  logic [AW-1:0]     idx;

  // In IDLE the live inputs describe the access; afterwards the latches do.
  always_comb begin
    start = (state == IDLE) &&
            (dmem_write_ready || dmem_read_ready);
    if (state == IDLE) begin
      acc_wr   = dmem_write_ready;
      acc_addr = dmem_write_ready ? dmem_write_address
                                  : dmem_read_address;
      acc_data = dmem_write_data;
      acc_byte = dmem_write_ready ? dmem_write_byte : 4'hF;
    end else begin
      acc_wr   = op_wr;
      acc_addr = addr_q;
      acc_data = data_q;
      acc_byte = byte_q;
    end
    lat = acc_wr ? 4'(WRITE_LATENCY) : 4'(READ_LATENCY);
    idx = AW'((acc_addr - BASE_ADDR) >> 2);
    enter_done = (start && lat == 4'd1) ||
                 (state == BUSY && cnt == 4'd0);
`ifdef DMEM_RESP_ERR_EN
    err = (acc_addr < BASE_ADDR) ||
          (((acc_addr - BASE_ADDR) >> 2) >= 32'(DEPTH_WORDS)) ||
          !be_legal(acc_byte);
`else
    err = 1'b0;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next;
  end

  always_comb begin
    next = state;
    case (state)
      IDLE: if (start) next = (lat == 4'd1) ? DONE : BUSY;
      BUSY: if (cnt == 4'd0) next = DONE;
      DONE: next = IDLE;
      default: next = IDLE;
    endcase
  end

  always_comb begin
    dmem_read_valid  = (state == DONE) && !op_wr;
    dmem_write_valid = (state == DONE) && op_wr;
`ifdef DMEM_RESP_ERR_EN
    dmem_error       = (state == DONE) && err;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      op_wr  <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      byte_q <= '0;
    end else if (start) begin
      cnt    <= lat - 4'd2;
      op_wr  <= acc_wr;
      addr_q <= acc_addr;
      data_q <= acc_data;
      byte_q <= acc_byte;
    end else if (state == BUSY && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk  (clk),
    .reset(reset),
    .we   (enter_done && acc_wr && !err),
    .re   (enter_done && !acc_wr),
    .rclr (err),
    .addr (idx),
    .wdata(acc_data),
    .wmask(acc_byte),
    .rdata(dmem_read_data)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder against a word-array reference model.
module tb_dmem_responder;

  localparam int          DEPTH = 256;
  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam int          RL    = 4;
  localparam int          WL    = 3;

  typedef struct {
    bit          wr;
    logic [31:0] data;
    int          due;
    bit          err;
  } exp_t;

  logic        clk = 0;
  logic        reset = 1;
  logic        rd_rdy = 0, wr_rdy = 0;
  logic [31:0] rd_addr = 0, wr_addr = 0, wr_data = 0;
  logic [3:0]  wr_be = 0;
  logic [31:0] rdata;
  logic        rvalid, wvalid;
`ifdef DMEM_RESP_ERR_EN
  logic        derr;
`endif

  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_rd = 0;
  logic [31:0] mem_m [int];
  exp_t        q[$];

  dmem_responder #(
    .DEPTH_WORDS  (DEPTH),
    .BASE_ADDR    (BASE),
    .READ_LATENCY (RL),
    .WRITE_LATENCY(WL)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .dmem_read_ready   (rd_rdy),
    .dmem_read_address (rd_addr),
    .dmem_write_ready  (wr_rdy),
    .dmem_write_address(wr_addr),
    .dmem_write_data   (wr_data),
    .dmem_write_byte   (wr_be),
    .dmem_read_data    (rdata),
    .dmem_read_valid   (rvalid),
`ifdef DMEM_RESP_ERR_EN
    .dmem_error        (derr),
`endif
    .dmem_write_valid  (wvalid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: a plain word array addressed modulo its depth.
  function automatic exp_t model(input bit wr, input logic [31:0] a,
                                 input logic [31:0] d,
                                 input logic [3:0] be, input int t0);
    exp_t e;
    int   i;
    logic [31:0] w;
    longint off;
    off = longint'(a) - longint'(BASE);
    i = int'((a - BASE) >> 2) % DEPTH;
    e.wr = wr;
    e.due = t0 + (wr ? WL : RL) - 1;
    e.err = 0;
`ifdef DMEM_RESP_ERR_EN
    if (off < 0 || (off / 4) >= DEPTH) e.err = 1;
    if (wr && !(be inside {4'h1, 4'h2, 4'h4, 4'h8,
                           4'h3, 4'hC, 4'hF})) e.err = 1;
`endif
    if (wr) begin
      e.data = 'x;
      if (!e.err) begin
        w = mem_m.exists(i) ? mem_m[i] : 32'h0;
        for (int k = 0; k < 4; k++)
          if (be[k]) w[8*k +: 8] = d[8*k +: 8];
        mem_m[i] = w;
      end
    end else begin
      e.data = e.err ? 32'h0 : mem_m[i];
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      checks++;
      if (rvalid || wvalid) begin
        if (rvalid && wvalid) begin
          errors++;
          $display("FAIL both_valid at cycle %0d", cyc);
        end else if (q.size() == 0) begin
          errors++;
          $display("FAIL spurious_valid r=%0b w=%0b cycle %0d",
                   rvalid, wvalid, cyc);
        end else begin
          exp_t e;
          e = q.pop_front();
          if (e.wr != wvalid || e.due != cyc ||
              (!e.wr && rdata !== e.data)
`ifdef DMEM_RESP_ERR_EN
              || derr !== e.err
`endif
             ) begin
            errors++;
            $display("FAIL resp got wr=%0b cyc=%0d data=%h need wr=%0b cyc=%0d data=%h",
                     wvalid, cyc, rdata, e.wr, e.due, e.data);
          end
          if (!e.wr) last_rd = e.data;
        end
      end else if (rdata !== last_rd) begin
        errors++;
        $display("FAIL rdata_hold got %h need %h cycle %0d",
                 rdata, last_rd, cyc);
      end
    end
  end

  task automatic access(input bit wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] be);
    @(negedge clk);
    if (wr) begin
      wr_rdy = 1; wr_addr = a; wr_data = d; wr_be = be;
    end else begin
      rd_rdy = 1; rd_addr = a;
    end
    @(posedge clk); #1;
    q.push_back(model(wr, a, d, be, cyc));
    wr_rdy = 0; rd_rdy = 0;
    wr_addr = $urandom; wr_data = $urandom; rd_addr = $urandom;
    wr_be = 4'($urandom);
    repeat ((wr ? WL : RL) - 1) @(posedge clk);
    @(posedge clk);
  endtask

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] need);
    checks++;
    if (got !== need) begin
      errors++;
      $display("FAIL %s got %h need %h", nm, got, need);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_rdata", rdata, 32'h0);
    chk("reset_rvalid", 32'(rvalid), 32'h0);
    chk("reset_wvalid", 32'(wvalid), 32'h0);
    #1 reset = 0;

    for (int i = 0; i < DEPTH; i++)
      access(1, BASE + 32'(4 * i), $urandom, 4'hF);

    access(1, 32'h10, 32'hDEADBEEF, 4'hF);
    access(0, 32'h10, 0, 0);
    access(1, 32'h30, 32'h11223344, 4'hF);
    access(1, 32'h30, 32'h0000AA00, 4'b0010);
    access(0, 32'h30, 0, 0);
    access(1, 32'h34, 32'hCAFEF00D, 4'b0000);
    access(0, 32'h34, 0, 0);

    // Both strobes together: write first, read held through DONE.
    @(negedge clk);
    wr_rdy = 1; wr_addr = 32'h20; wr_data = 32'h55; wr_be = 4'hF;
    rd_rdy = 1; rd_addr = 32'h20;
    @(posedge clk); #1;
    q.push_back(model(1, 32'h20, 32'h55, 4'hF, cyc));
    wr_rdy = 0;
    repeat (WL) @(posedge clk);
    @(posedge clk); #1;
    q.push_back(model(0, 32'h20, 0, 0, cyc));
    repeat (RL) @(posedge clk);
    #1 rd_rdy = 0;
    repeat (3) @(posedge clk);

    access(1, BASE + 32'(4 * DEPTH), 32'hA5A50001, 4'hF);
    access(1, 32'h44, 32'h12345678, 4'b0101);
    access(0, 32'h02, 0, 0);
    access(0, 32'h44, 0, 0);

    // Reset while the write is still counting down.
    access(0, 32'h10, 0, 0);
    @(negedge clk);
    wr_rdy = 1; wr_addr = 32'h10; wr_data = 32'h0; wr_be = 4'hF;
    @(posedge clk); #1;
    wr_rdy = 0;
    @(posedge clk); #2;
    reset = 1;
    #1;
    chk("rst_mid_rdata", rdata, 32'h0);
    chk("rst_mid_wvalid", 32'(wvalid), 32'h0);
    chk("rst_mid_rvalid", 32'(rvalid), 32'h0);
    last_rd = 0;
    @(negedge clk);
    @(negedge clk);
    #1 reset = 0;
    access(0, 32'h10, 0, 0);

    for (int n = 0; n < 300; n++) begin
      logic [31:0] a;
      a = BASE + (32'($urandom_range(0, 2 * DEPTH - 1)) << 2)
               + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1)
        access(1, a, $urandom, 4'($urandom));
      else
        access(0, a, 0, 0);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
